// File: rtl/joypad_serializer.sv
// Parallel-to-serial game controller ports: per-port button registers, strobe reload and
// falling-edge shift. Define JOYPAD_TURBO_EN to build in strobe-driven turbo gating.
module joypad_serializer #(
  parameter int unsigned PORTS         = 2,
  parameter int unsigned BITS          = 8,
  parameter logic        FILL          = 1'b1,
  parameter int unsigned TURBO_STROBES = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         btn_wr,
  input  logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] btn_sel,
  input  logic [BITS-1:0]                              btn_data,
  input  logic [PORTS*BITS-1:0]                        turbo_mask,
  input  logic                                         joypad_strobe,
  input  logic [PORTS-1:0]                             joypad_clock,
  output logic [PORTS-1:0]                             joypad_data,
  output logic [PORTS-1:0]                             overrun
);

  localparam int unsigned     CntW    = $clog2(BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(BITS + 1);

  logic [BITS-1:0]  r_btn        [PORTS];
  logic [BITS-1:0]  r_shift      [PORTS];
  logic [CntW-1:0]  r_cnt        [PORTS];
  logic [PORTS-1:0] r_overrun;
  logic [PORTS-1:0] r_last_clock;

  logic [BITS-1:0]  w_btn_next   [PORTS];
  logic [BITS-1:0]  w_shift_next [PORTS];
  logic [CntW-1:0]  w_cnt_next   [PORTS];
  logic [BITS-1:0]  w_gate       [PORTS];
  logic [PORTS-1:0] w_overrun_next;
  logic [PORTS-1:0] w_fall;
  logic [31:0]      w_sel;

  assign w_sel  = 32'(btn_sel);
  assign w_fall = r_last_clock & ~joypad_clock;

`ifdef JOYPAD_TURBO_EN
  localparam int unsigned    TsW    = (TURBO_STROBES > 1) ? $clog2(TURBO_STROBES) : 1;
  localparam logic [TsW-1:0] TsLast = TsW'(TURBO_STROBES - 1);

  logic           r_strobe_prev;
  logic           r_turbo_phase;
  logic [TsW-1:0] r_strobe_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_prev <= 1'b0;
      r_turbo_phase <= 1'b0;
      r_strobe_cnt  <= '0;
    end else begin
      r_strobe_prev <= joypad_strobe;
      if (joypad_strobe && !r_strobe_prev) begin
        if (r_strobe_cnt == TsLast) begin
          r_strobe_cnt  <= '0;
          r_turbo_phase <= ~r_turbo_phase;
        end else begin
          r_strobe_cnt <= r_strobe_cnt + 1'b1;
        end
      end
    end
  end

  // Masked buttons read as released during the low turbo phase.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_gate[p] = ~turbo_mask[p*BITS +: BITS] | {BITS{r_turbo_phase}};
    end
  end
`else
  logic w_unused_turbo_mask;
  assign w_unused_turbo_mask = ^turbo_mask;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_gate[p] = '1;
    end
  end
`endif

  // Reload has priority over a coincident falling edge; writes only land in r_btn.
  always_comb begin
    w_overrun_next = r_overrun;
    for (int p = 0; p < PORTS; p++) begin
      w_btn_next[p]   = r_btn[p];
      w_shift_next[p] = r_shift[p];
      w_cnt_next[p]   = r_cnt[p];
      if (btn_wr && (w_sel == 32'(p))) begin
        w_btn_next[p] = btn_data;
      end
      if (joypad_strobe) begin
        w_shift_next[p]   = r_btn[p] & w_gate[p];
        w_cnt_next[p]     = '0;
        w_overrun_next[p] = 1'b0;
      end else if (w_fall[p]) begin
        w_shift_next[p] = {FILL, r_shift[p][BITS-1:1]};
        if (r_cnt[p] == CntFull) begin
          w_overrun_next[p] = 1'b1;
        end
        if (r_cnt[p] != CntSat) begin
          w_cnt_next[p] = r_cnt[p] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PORTS; p++) begin
        r_btn[p]   <= '0;
        r_shift[p] <= '0;
        r_cnt[p]   <= '0;
      end
      r_overrun    <= '0;
      r_last_clock <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        r_btn[p]   <= w_btn_next[p];
        r_shift[p] <= w_shift_next[p];
        r_cnt[p]   <= w_cnt_next[p];
      end
      r_overrun    <= w_overrun_next;
      r_last_clock <= joypad_clock;
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      joypad_data[p] = r_shift[p][0];
    end
  end

  assign overrun = r_overrun;

endmodule

// File: doc/joypad_serializer.md
JOYPAD_SERIALIZER -- requirements
Module: joypad_serializer

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of controller ports, range 1..4.
REQ-002 SHALL have parameter BITS, default 8: shift length per port, range 8..24; 24 covers SNES-style pads.
REQ-003 SHALL have parameter FILL, default 1'b1: bit shifted in and driven once a port's reads exceed BITS.
REQ-004 SHALL have parameter TURBO_STROBES, default 4, minimum 1: strobe rising edges per turbo phase toggle.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port btn_wr, input, 1: write btn_data into the button register of port btn_sel.
REQ-008 SHALL have port btn_sel, input, $clog2(PORTS) with minimum 1: target port for btn_wr.
REQ-009 SHALL have port btn_data, input, BITS: button states, 1 = pressed, bit 0 shifted out first.
REQ-010 SHALL have port turbo_mask, input, PORTS*BITS: per-port, per-button turbo enable; port p uses slice [p*BITS +: BITS].
REQ-011 SHALL have port joypad_strobe, input, 1: latch/reload request from the console core.
REQ-012 SHALL have port joypad_clock, input, PORTS: per-port read clocks; shift occurs on the falling edge.
REQ-013 SHALL have port joypad_data, output, PORTS: current serial bit per port, bit 0 of the shift register.
REQ-014 SHALL have port overrun, output, PORTS: sticky flag, set when a port is read more than BITS times since the last strobe.

Function
REQ-015 SHALL keep one BITS-wide button register per port; btn_wr at a clock edge updates only the register selected by btn_sel.
REQ-016 SHALL ignore btn_wr when btn_sel >= PORTS.
REQ-017 SHALL sample joypad_clock into last_clock on every clk edge; a falling edge is last_clock[p]=1 and joypad_clock[p]=0.
REQ-018 While joypad_strobe=1, SHALL reload every shift register each cycle from its button register ANDed with the turbo gate, and SHALL clear the read count and overrun of every port.
REQ-019 The turbo gate SHALL be ~turbo_mask[p] | {BITS{turbo_phase}}; masked buttons read as released while turbo_phase=0.
REQ-020 While joypad_strobe=0, SHALL on a falling edge of port p shift that port right by one, insert FILL at the MSB and increment its read count, saturating at BITS+1.
REQ-021 SHALL set overrun[p] on a falling edge when the read count already equals BITS; joypad_data[p] is then FILL.
REQ-022 When strobe=1 and a falling edge occur in the same cycle, the reload SHALL win and no shift SHALL occur.
REQ-023 A btn_wr during a read sequence SHALL NOT alter the shift register until the next reload.
REQ-024 The btn_data value written by btn_wr at edge N SHALL be visible in a reload at edge N+1 at the earliest; the new register value is not bypassed into the same-edge reload.
REQ-025 A strobe edge counter SHALL count rising edges of joypad_strobe, wrap at TURBO_STROBES-1 and toggle turbo_phase on wrap.
REQ-026 joypad_data[p] SHALL be registered, taken directly from shift register bit 0, with no combinational path from the inputs.

Reset
REQ-027 On reset_n=0, SHALL asynchronously clear all button registers, shift registers, read counts, overrun, last_clock, the strobe counter, the previous-strobe sample and turbo_phase.
REQ-028 joypad_data SHALL be 0 and overrun SHALL be 0 during reset and after release until the first reload or shift.
REQ-029 On release, SHALL NOT detect a falling edge in the first cycle; last_clock=0 guarantees this.

Configuration
REQ-030 Macro JOYPAD_TURBO_EN SHALL compile turbo in: the strobe counter, turbo_phase and the REQ-019 gating.
REQ-031 Without JOYPAD_TURBO_EN, turbo_mask SHALL remain a port but be ignored, the gate SHALL be all ones and no turbo state SHALL exist.

Verification
REQ-032 Load port 0 = 8'h81, strobe 1->0, 8 falling clocks: joypad_data[0] reads 1,0,0,0,0,0,0,1; overrun[0]=0.
REQ-033 Continue with a 9th and 10th falling clock: joypad_data[0]=FILL (1) both times; overrun[0]=1 after the 9th; next strobe clears overrun[0] to 0.
REQ-034 Strobe high and a falling clock in the same cycle, then strobe low: joypad_data[0] = bit 0 of the button register, no shift occurred.
REQ-035 btn_wr port 1 = 8'hFF after 3 reads of port 1 (old value 8'h00): reads 4-8 return 0; after the next strobe, read 1 returns 1.
REQ-036 JOYPAD_TURBO_EN, TURBO_STROBES=2, port 0 buttons 8'h01, mask bit 0 set, six strobes each followed by one read: first bit reads 0,1,1,0,0,1.
REQ-037 Assert reset_n=0 mid-sequence after 4 reads: joypad_data=0 and overrun=0 immediately; a read after release and strobe returns the button register value 0.
